// File: rtl/usb_fs_nb_in_pe.sv
// Full-speed USB IN protocol engine: answers IN tokens with DATA/NAK/STALL,
// streams endpoint bytes to the transmitter and tracks per-endpoint data toggles.
module usb_fs_nb_in_pe #(
    parameter int unsigned NumInEps         = 1,
    parameter int unsigned MaxInPktSizeByte = 32,
    parameter int unsigned AckTimeoutCnt    = 80,
    localparam int unsigned InEpW = (NumInEps > 1) ? $clog2(NumInEps) : 1,
    localparam int unsigned PktW  = $clog2(MaxInPktSizeByte)
) (
    input  logic                clk_48mhz_i,
    input  logic                rst_ni,

    input  logic                link_reset_i,
    input  logic [6:0]          dev_addr_i,

    output logic [3:0]          in_ep_current_o,
    output logic                in_ep_rollback_o,
    output logic                in_ep_acked_o,
    output logic                in_ep_newpkt_o,

    output logic [PktW-1:0]     in_ep_get_addr_o,
    output logic                in_ep_data_get_o,
    input  logic [7:0]          in_ep_data_i,
    input  logic [NumInEps-1:0] in_ep_data_done_i,

    input  logic [NumInEps-1:0] in_ep_stall_i,
    input  logic [NumInEps-1:0] in_ep_has_data_i,
    input  logic [NumInEps-1:0] in_ep_iso_i,
    input  logic [NumInEps-1:0] data_toggle_clear_i,

    input  logic                rx_pkt_start_i,
    input  logic                rx_pkt_end_i,
    input  logic                rx_pkt_valid_i,
    input  logic [3:0]          rx_pid_i,
    input  logic [6:0]          rx_addr_i,
    input  logic [3:0]          rx_endp_i,

    output logic                tx_pkt_start_o,
    input  logic                tx_pkt_end_i,
    output logic [3:0]          tx_pid_o,
    output logic                tx_data_avail_o,
    input  logic                tx_data_get_i,
    output logic [7:0]          tx_data_o
);

    // state      | meaning
    // StIdle     | waiting for an IN token
    // StRcvdIn   | IN accepted, handshake/data PID issued this cycle
    // StSendData | streaming endpoint bytes to the transmitter
    // StWaitAck  | data sent, waiting for host ACK or timeout
    typedef enum logic [1:0] {
        StIdle,
        StRcvdIn,
        StSendData,
        StWaitAck
    } state_e;

    state_e                state_q, state_d;
    logic [3:0]            cur_ep_q;
    logic [PktW-1:0]       get_addr_q;
    logic [15:0]           timer_q;
    logic [NumInEps-1:0]   toggle_q, toggle_d;
    logic                  acked_q, acked_d;
    logic                  rollback_q, rollback_d;
    logic                  newpkt_q, newpkt_d;
    logic                  toggle_flip;
    logic [3:0]            tx_pid;
    logic [NumInEps-1:0]   ep_sel;
    logic                  token_ok, in_tok, setup_tok, ack_ok, timeout;
    logic                  stall_sel, has_data_sel, iso_sel, toggle_sel, done_sel;
    logic                  data_get;
    logic                  unused_rx_start;

    assign unused_rx_start = rx_pkt_start_i;

    assign token_ok  = rx_pkt_end_i && rx_pkt_valid_i && (rx_pid_i[1:0] == 2'b01) &&
                       (rx_addr_i == dev_addr_i) && ({28'd0, rx_endp_i} < 32'(NumInEps));
    assign in_tok    = token_ok && (rx_pid_i == 4'b1001);
    assign setup_tok = token_ok && (rx_pid_i == 4'b1101);
    assign ack_ok    = rx_pkt_end_i && rx_pkt_valid_i && (rx_pid_i == 4'b0010);
    assign timeout   = (timer_q >= 16'(AckTimeoutCnt));

    // Accepted endpoints are always below NumInEps, so the low InEpW bits identify it.
    always_comb begin
        ep_sel = '0;
        for (int unsigned i = 0; i < NumInEps; i++) begin
            ep_sel[i] = (cur_ep_q[InEpW-1:0] == InEpW'(i));
        end
    end

    assign stall_sel    = |(in_ep_stall_i & ep_sel);
    assign has_data_sel = |(in_ep_has_data_i & ep_sel);
    assign iso_sel      = |(in_ep_iso_i & ep_sel);
    assign toggle_sel   = |(toggle_q & ep_sel);
    assign done_sel     = |(in_ep_data_done_i & ep_sel);

    assign tx_data_avail_o  = (state_q == StSendData) && !done_sel;
    assign data_get         = tx_data_get_i && tx_data_avail_o;
    assign in_ep_data_get_o = data_get;
    assign tx_data_o        = in_ep_data_i;

    always_comb begin
        state_d     = state_q;
        acked_d     = 1'b0;
        rollback_d  = 1'b0;
        newpkt_d    = 1'b0;
        toggle_flip = 1'b0;
        tx_pid      = 4'b0000;
        unique case (state_q)
            StIdle: begin
                if (in_tok) begin
                    state_d  = StRcvdIn;
                    newpkt_d = 1'b1;
                end
            end
            StRcvdIn: begin
                if (stall_sel) begin
                    tx_pid  = 4'b1110;
                    state_d = StIdle;
                end else if (!has_data_sel) begin
                    tx_pid  = 4'b1010;
                    state_d = StIdle;
                end else begin
                    tx_pid  = (toggle_sel && !iso_sel) ? 4'b1011 : 4'b0011;
                    state_d = StSendData;
                end
            end
            StSendData: begin
                if (tx_pkt_end_i) begin
                    if (iso_sel) begin
                        acked_d = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d = StWaitAck;
                    end
                end
            end
            StWaitAck: begin
                if (ack_ok) begin
                    acked_d     = 1'b1;
                    toggle_flip = 1'b1;
                    state_d     = StIdle;
                end else if (rx_pkt_end_i || timeout) begin
                    rollback_d = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // Bus reset aborts silently: no handshake side effects survive it.
        if (link_reset_i) begin
            state_d     = StIdle;
            acked_d     = 1'b0;
            rollback_d  = 1'b0;
            newpkt_d    = 1'b0;
            toggle_flip = 1'b0;
        end
    end

    assign tx_pkt_start_o = (state_q == StRcvdIn);
    assign tx_pid_o       = tx_pid;

    always_comb begin
        toggle_d = toggle_q;
        for (int unsigned i = 0; i < NumInEps; i++) begin
            if (link_reset_i || data_toggle_clear_i[i]) begin
                toggle_d[i] = 1'b0;
            end else if (toggle_flip && ep_sel[i]) begin
                toggle_d[i] = ~toggle_q[i];
            end else if (setup_tok && (rx_endp_i == 4'(i))) begin
                toggle_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cur_ep_q   <= '0;
            get_addr_q <= '0;
            timer_q    <= '0;
            toggle_q   <= '0;
            acked_q    <= 1'b0;
            rollback_q <= 1'b0;
            newpkt_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            toggle_q   <= toggle_d;
            acked_q    <= acked_d;
            rollback_q <= rollback_d;
            newpkt_q   <= newpkt_d;
            if (newpkt_d) begin
                cur_ep_q   <= rx_endp_i;
                get_addr_q <= '0;
            end else if (data_get && (get_addr_q != {PktW{1'b1}})) begin
                get_addr_q <= get_addr_q + PktW'(1);
            end
            if ((state_q == StWaitAck) && (state_d == StWaitAck)) begin
                if (timer_q != 16'hffff) begin
                    timer_q <= timer_q + 16'd1;
                end
            end else begin
                timer_q <= '0;
            end
        end
    end

    assign in_ep_current_o  = cur_ep_q;
    assign in_ep_get_addr_o = get_addr_q;
    assign in_ep_acked_o    = acked_q;
    assign in_ep_rollback_o = rollback_q;
    assign in_ep_newpkt_o   = newpkt_q;

endmodule

// File: doc/usb_fs_nb_in_pe.md
USB_FS_NB_IN_PE -- requirements
Module: usb_fs_nb_in_pe

Interface
REQ-001 Parameters SHALL be: NumInEps, default 1 (5 bits), number of IN endpoints; MaxInPktSizeByte, default 32, buffer size in bytes; AckTimeoutCnt, default 80, ACK wait limit in clocks; InEpW = clog2(NumInEps); PktW = clog2(MaxInPktSizeByte).
REQ-002 Clock and reset SHALL be: clk_48mhz_i, in, 1, single clock; rst_ni, in, 1, reset, asynchronous, active-low.
REQ-003 Control ports SHALL be: link_reset_i, in, 1, USB bus reset; dev_addr_i, in, 7, device address.
REQ-004 Endpoint status ports SHALL be: in_ep_current_o, out, 4, latched endpoint; in_ep_rollback_o, out, 1, transfer failed; in_ep_acked_o, out, 1, host ACKed; in_ep_newpkt_o, out, 1, transfer started.
REQ-005 Endpoint data ports SHALL be: in_ep_get_addr_o, out, PktW, buffer read address; in_ep_data_get_o, out, 1, byte consumed; in_ep_data_i, in, 8, byte at get_addr; in_ep_data_done_i, in, NumInEps, no bytes remain.
REQ-006 Per-endpoint inputs SHALL be: in_ep_stall_i, in, NumInEps; in_ep_has_data_i, in, NumInEps; in_ep_iso_i, in, NumInEps; data_toggle_clear_i, in, NumInEps.
REQ-007 Receive ports SHALL be: rx_pkt_start_i, in, 1; rx_pkt_end_i, in, 1; rx_pkt_valid_i, in, 1; rx_pid_i, in, 4; rx_addr_i, in, 7; rx_endp_i, in, 4.
REQ-008 Transmit ports SHALL be: tx_pkt_start_o, out, 1; tx_pkt_end_i, in, 1; tx_pid_o, out, 4; tx_data_avail_o, out, 1; tx_data_get_i, in, 1; tx_data_o, out, 8.

Function
REQ-009 A token SHALL be accepted only when all hold: rx_pkt_end_i, rx_pkt_valid_i, rx_pid_i[1:0]=01, rx_addr_i=dev_addr_i, rx_endp_i<NumInEps.
REQ-010 The FSM SHALL have states StIdle, StRcvdIn, StSendData and StWaitAck.
REQ-011 In StIdle, an accepted IN token (PID 1001) SHALL move the FSM to StRcvdIn, latch rx_endp_i into in_ep_current_o, pulse in_ep_newpkt_o for one cycle and clear in_ep_get_addr_o to 0.
REQ-012 In StRcvdIn, tx_pkt_start_o SHALL pulse for exactly one cycle with tx_pid_o selected in this priority:
- stall set: STALL 1110, then StIdle.
- has_data clear: NAK 1010, then StIdle.
- otherwise: DATA1 1011 if toggle=1, else DATA0 0011, then StSendData.
- iso endpoint: always DATA0.
REQ-013 tx_data_avail_o SHALL equal (state==StSendData) and !in_ep_data_done_i[ep].
REQ-014 tx_data_o SHALL equal in_ep_data_i combinationally.
REQ-015 When tx_data_get_i and tx_data_avail_o are both high, in_ep_get_addr_o SHALL increment on the next clock, saturating at all-ones, and in_ep_data_get_o SHALL pulse for that cycle.
REQ-016 In StSendData, tx_pkt_end_i SHALL move the FSM to StWaitAck, or for an iso endpoint to StIdle with an in_ep_acked_o pulse and no toggle change.
REQ-017 In StWaitAck, a 16-bit timer SHALL count from 0 on entry.
REQ-018 In StWaitAck, a valid ACK (rx_pkt_end_i, rx_pkt_valid_i, PID 0010) SHALL pulse in_ep_acked_o, invert that endpoint's toggle and return to StIdle.
REQ-019 In StWaitAck, any other rx_pkt_end_i, or the timer reaching AckTimeoutCnt, SHALL pulse in_ep_rollback_o, leave the toggle unchanged and return to StIdle.
REQ-020 A setup token (PID 1101) to endpoint n SHALL set toggle[n]=1 in any state.
REQ-021 data_toggle_clear_i[n] SHALL force toggle[n]=0 and SHALL take priority over an ACK or setup update in the same cycle.
REQ-022 IN tokens received outside StIdle SHALL be ignored.
REQ-023 tx_pid_o SHALL be 0000 whenever tx_pkt_start_o is low.
REQ-024 link_reset_i SHALL force StIdle and clear all toggles on the next clock, with no acked or rollback pulse.

Reset
REQ-025 While rst_ni is low, all of the following SHALL be 0 and the FSM SHALL be in StIdle:
- outputs, including in_ep_current_o, in_ep_get_addr_o and toggles;
- the timer.
REQ-026 Deasserting rst_ni mid-transfer SHALL resume in StIdle with no pulses.

Verification
REQ-027 Basic IN: has_data=1, toggle=0, IN to addr 5/ep0 with dev_addr 5, 4 byte gets, tx_pkt_end, ACK -> DATA0 sent, get_addr 0->4, acked pulse, toggle=1.
REQ-028 NAK/STALL: has_data=0 -> PID 1010, state StIdle; stall=1 with has_data=1 -> PID 1110, no data.
REQ-029 Timeout: no ACK for AckTimeoutCnt clocks -> rollback pulse, toggle unchanged, next IN sends the same DATA PID.
REQ-030 Iso: iso=1, toggle=1 -> DATA0 sent, no StWaitAck, acked pulse at tx_pkt_end, toggle stays 1.
REQ-031 Simultaneity: ACK in the same cycle as data_toggle_clear_i -> toggle=0; SETUP then IN -> DATA1.
REQ-032 Address filter: IN with rx_addr != dev_addr, or ep >= NumInEps -> no tx_pkt_start, no newpkt.
